oled_fb_reader: RTL and testbench

Double-buffered, scaling framebuffer between the capture/generator side and the `oled_video` SSD1351 driver. A producer writes RGB pixels of configurable channel width into the back bank. The display side maps the driver's `x`/`y` scan position into the front bank with integer power-of-two upscaling and a centring offset, then expands to RGB565. Bank swaps are requested by the producer and committed only at a display frame boundary, so the panel never shows a torn frame.

---
 rtl/fb_pkg.sv | 42 ++++
 rtl/fb_dp_bram.sv | 43 ++++
 rtl/oled_fb_reader.sv | 175 +++++++++++++++++
 tb/tb_oled_fb_reader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_pkg
// Description : Shared constants and helpers for the scaling framebuffer:
//               RGB565 field widths, swap FSM encoding, address-width helper
//               and the per-channel colour expansion function.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

    localparam int R565_W = 5;
    localparam int G565_W = 6;
    localparam int B565_W = 5;

    // Swap FSM encoding
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    // Address width for a given depth, never narrower than one bit
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Expand (or truncate) an nb-bit channel held in value[nb-1:0] to t bits.
    // Bit k of the result, counted from the MSB, is source bit (k mod nb)
    // counted from the MSB: this gives MSB replication when nb < t (repeated
    // as often as needed) and plain truncation when nb >= t. The result sits
    // in the low t bits.
    function automatic logic [7:0] expand_ch(input logic [7:0] value,
                                             input int nb, input int t);
        logic [7:0] res;
        res = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < t) begin
                res[t - 1 - i] = value[nb - 1 - (i % nb)];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_dp_bram.sv
`default_nettype none
// ============================================================================
// Module      : fb_dp_bram
// Description : Simple dual-port inferred block RAM: one write port and one
//               registered read port on a single clock. Storage is rounded up
//               to a power of two so callers can use the top address bit as a
//               bank selector.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_dp_bram
    import fb_pkg::*;
#(
    parameter  int DEPTH  = 2,
    parameter  int WIDTH  = 8,
    localparam int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [0:(1 << ADDR_W)-1];
    logic [WIDTH-1:0] rdata_q;

    // Write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port (no reset, maps onto BRAM output register)
    always_ff @(posedge clk) begin
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/oled_fb_reader.sv
`default_nettype none
// ============================================================================
// Module      : oled_fb_reader
// Description : Double-buffered scaling framebuffer feeding the SSD1351
//               driver. Producer writes the back bank; display side maps the
//               panel scan position into the front bank with power-of-two
//               upscaling and a centring offset, then expands to RGB565.
//               Bank swaps commit only on a display frame boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module oled_fb_reader
    import fb_pkg::*;
#(
    parameter  int          IMG_COLS = 80,
    parameter  int          IMG_ROWS = 60,
    parameter  int          NB_R     = 4,
    parameter  int          NB_G     = 4,
    parameter  int          NB_B     = 4,
    parameter  int          X_SIZE   = 128,
    parameter  int          Y_SIZE   = 128,
    parameter  int          SCALE_SH = 0,
    parameter  int          X_OFF    = 24,
    parameter  int          Y_OFF    = 34,
    parameter  logic [15:0] BORDER   = 16'h0000,
    localparam int          COL_W    = addr_w(IMG_COLS),
    localparam int          ROW_W    = addr_w(IMG_ROWS),
    localparam int          PIX_W    = NB_R + NB_G + NB_B
) (
    input  logic             clk,
    input  logic             rst,
    // producer side
    input  logic             wr_en,
    input  logic [COL_W-1:0] wr_col,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             swap_req,
    output logic             swap_pending,
    output logic             swap_ack,
    output logic             front_bank,
    // display side
    input  logic [6:0]       x,
    input  logic [6:0]       y,
    input  logic             next_pixel,
    output logic [15:0]      color
);

    localparam int NPIX      = IMG_COLS * IMG_ROWS;
    localparam int LIN_W     = addr_w(NPIX);
    localparam int MEM_DEPTH = 2 * NPIX;
    localparam int WIN_W     = IMG_COLS << SCALE_SH;
    localparam int WIN_H     = IMG_ROWS << SCALE_SH;

    // ------------------------------------------------------------------
    // Swap FSM
    // ------------------------------------------------------------------
    logic [0:0] state_q, state_d;
    logic       front_bank_q, front_bank_d;
    logic       swap_ack_q, swap_ack_d;
    logic       frame_end;
    logic       commit;

    assign frame_end = next_pixel
                     && (x == 7'(X_SIZE - 1))
                     && (y == 7'(Y_SIZE - 1));

    // State register: FSM state, displayed bank and acknowledge pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            front_bank_q <= 1'b0;
            swap_ack_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            front_bank_q <= front_bank_d;
            swap_ack_q   <= swap_ack_d;
        end
    end

    // Next state: requests are only accepted in IDLE, commit on frame end
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (swap_req)  state_d = ST_PENDING;
            ST_PENDING: if (frame_end) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs: commit strobe toggles the bank and raises the ack pulse
    always_comb begin
        commit       = (state_q == ST_PENDING) && frame_end;
        front_bank_d = front_bank_q ^ commit;
        swap_ack_d   = commit;
        swap_pending = (state_q == ST_PENDING);
    end

    assign front_bank = front_bank_q;
    assign swap_ack   = swap_ack_q;

    // ------------------------------------------------------------------
    // Write side: out-of-range coordinates are dropped rather than wrapped
    // ------------------------------------------------------------------
    logic             wr_ok;
    logic [LIN_W-1:0] wr_lin;

    assign wr_ok  = wr_en
                 && (int'(wr_col) < IMG_COLS)
                 && (int'(wr_row) < IMG_ROWS);
    assign wr_lin = LIN_W'(int'(wr_row) * IMG_COLS + int'(wr_col));

    // ------------------------------------------------------------------
    // Read side, stage 1: window test and address into the front bank
    // ------------------------------------------------------------------
    int               x_rel;
    int               y_rel;
    logic             rd_win;
    logic [LIN_W-1:0] rd_lin;

    assign x_rel  = int'(x) - X_OFF;
    assign y_rel  = int'(y) - Y_OFF;
    assign rd_win = (x_rel >= 0) && (x_rel < WIN_W)
                 && (y_rel >= 0) && (y_rel < WIN_H);
    // Outside the window the address is meaningless; rd_win masks it later
    assign rd_lin = LIN_W'((y_rel >>> SCALE_SH) * IMG_COLS + (x_rel >>> SCALE_SH));

    logic [PIX_W-1:0] rdata;

    fb_dp_bram #(
        .DEPTH (MEM_DEPTH),
        .WIDTH (PIX_W)
    ) u_bram (
        .clk     (clk),
        .we_i    (wr_ok),
        .waddr_i ({~front_bank_q, wr_lin}),
        .wdata_i (wr_data),
        .raddr_i ({front_bank_q, rd_lin}),
        .rdata_o (rdata)
    );

    // Window flag travels alongside the BRAM read
    logic win_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            win_q <= 1'b0;
        end else begin
            win_q <= rd_win;
        end
    end

    // ------------------------------------------------------------------
    // Read side, stage 2: channel expansion and output register
    // ------------------------------------------------------------------
    logic [R565_W-1:0] r5;
    logic [G565_W-1:0] g6;
    logic [B565_W-1:0] b5;
    logic [15:0]       color_q;

    assign r5 = R565_W'(expand_ch(8'(rdata[PIX_W-1 -: NB_R]),       NB_R, R565_W));
    assign g6 = G565_W'(expand_ch(8'(rdata[NB_G+NB_B-1 -: NB_G]),   NB_G, G565_W));
    assign b5 = B565_W'(expand_ch(8'(rdata[NB_B-1:0]),              NB_B, B565_W));

    // Output colour: pixel inside the window, border colour outside
    always_ff @(posedge clk) begin
        if (!rst) begin
            color_q <= BORDER;
        end else begin
            color_q <= win_q ? {r5, g6, b5} : BORDER;
        end
    end

    assign color = color_q;

endmodule
`default_nettype wire

// File: tb/tb_oled_fb_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_oled_fb_reader
// Description : Scoreboard bench for oled_fb_reader. Two instances: the
//               default 80x60 centred configuration and a 64x64 2x-upscaled
//               configuration with a non-zero border colour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oled_fb_reader;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic        wr_en = 1'b0;
    logic [6:0]  wr_col = '0;
    logic [5:0]  wr_row = '0;
    logic [11:0] wr_data = '0;
    logic        swap_req = 1'b0;
    logic        swap_pending, swap_ack, front_bank;
    logic [6:0]  x = '0, y = '0;
    logic        next_pixel = 1'b0;
    logic [15:0] color;

    // scaled instance
    logic        wr_en_s = 1'b0;
    logic [5:0]  wr_col_s = '0;
    logic [5:0]  wr_row_s = '0;
    logic [11:0] wr_data_s = '0;
    logic        swap_req_s = 1'b0;
    logic        swap_pending_s, swap_ack_s, front_bank_s;
    logic [6:0]  x_s = '0, y_s = '0;
    logic        next_pixel_s = 1'b0;
    logic [15:0] color_s;

    oled_fb_reader dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_data(wr_data),
        .swap_req(swap_req), .swap_pending(swap_pending), .swap_ack(swap_ack),
        .front_bank(front_bank), .x(x), .y(y), .next_pixel(next_pixel),
        .color(color)
    );

    oled_fb_reader #(
        .IMG_COLS(64), .IMG_ROWS(64), .SCALE_SH(1),
        .X_OFF(0), .Y_OFF(0), .BORDER(16'h001F)
    ) dut_s (
        .clk(clk), .rst(rst),
        .wr_en(wr_en_s), .wr_col(wr_col_s), .wr_row(wr_row_s), .wr_data(wr_data_s),
        .swap_req(swap_req_s), .swap_pending(swap_pending_s), .swap_ack(swap_ack_s),
        .front_bank(front_bank_s), .x(x_s), .y(y_s), .next_pixel(next_pixel_s),
        .color(color_s)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    localparam int SEL_COLOR   = 0;
    localparam int SEL_FRONT   = 1;
    localparam int SEL_PENDING = 2;
    localparam int SEL_ACK     = 3;
    localparam int SEL_COLOR_S = 4;
    localparam int SEL_FRONT_S = 5;

    typedef struct {
        string       name;
        int          sel;
        logic [15:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic expect_v(input string name, input int sel, input logic [15:0] e);
        exp_t it;
        it.name = name;
        it.sel  = sel;
        it.exp  = e;
        sb_q.push_back(it);
    endtask

    // Monitor: compares queued expectations against outputs on the falling edge
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t        it;
            logic [15:0] act;
            it = sb_q.pop_front();
            case (it.sel)
                SEL_COLOR:   act = color;
                SEL_FRONT:   act = {15'd0, front_bank};
                SEL_PENDING: act = {15'd0, swap_pending};
                SEL_ACK:     act = {15'd0, swap_ack};
                SEL_COLOR_S: act = color_s;
                SEL_FRONT_S: act = {15'd0, front_bank_s};
                default:     act = 16'hxxxx;
            endcase
            checks++;
            if (act !== it.exp) begin
                failures++;
                $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [6:0] c, input logic [5:0] r, input logic [11:0] d);
        wr_en = 1'b1; wr_col = c; wr_row = r; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wr_s(input logic [5:0] c, input logic [5:0] r, input logic [11:0] d);
        wr_en_s = 1'b1; wr_col_s = c; wr_row_s = r; wr_data_s = d;
        tick();
        wr_en_s = 1'b0;
    endtask

    task automatic frame_end(input bit scaled);
        if (scaled) begin
            x_s = 7'd127; y_s = 7'd127; next_pixel_s = 1'b1;
            tick();
            next_pixel_s = 1'b0;
        end else begin
            x = 7'd127; y = 7'd127; next_pixel = 1'b1;
            tick();
            next_pixel = 1'b0;
        end
    endtask

    task automatic rd(input string name, input logic [6:0] px, input logic [6:0] py,
                      input logic [15:0] e);
        x = px; y = py;
        tick();
        tick();
        expect_v(name, SEL_COLOR, e);
    endtask

    task automatic rd_s(input string name, input logic [6:0] px, input logic [6:0] py,
                        input logic [15:0] e);
        x_s = px; y_s = py;
        tick();
        tick();
        expect_v(name, SEL_COLOR_S, e);
    endtask

    initial begin
        // ---------------- reset ----------------
        rst = 1'b0;
        tick(); tick(); tick();
        expect_v("rst_color",   SEL_COLOR,   16'h0000);
        expect_v("rst_front",   SEL_FRONT,   16'h0000);
        expect_v("rst_pending", SEL_PENDING, 16'h0000);
        expect_v("rst_ack",     SEL_ACK,     16'h0000);
        expect_v("rst_color_s", SEL_COLOR_S, 16'h001F);
        rst = 1'b1;
        tick(); tick();
        expect_v("border_0_0", SEL_COLOR, 16'h0000);

        // ---------------- fill back bank, swap ----------------
        wr(7'd0,  6'd0,  12'hF00);
        wr(7'd1,  6'd0,  12'h8C3);
        wr(7'd2,  6'd0,  12'hFFF);
        wr(7'd0,  6'd1,  12'h123);
        wr(7'd79, 6'd59, 12'h0F0);
        wr(7'd80, 6'd0,  12'hFFF);     // column out of range, must not land on (0,1)
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        expect_v("pend_after_req", SEL_PENDING, 16'h0001);
        expect_v("front_before",   SEL_FRONT,   16'h0000);
        frame_end(1'b0);
        expect_v("ack_commit",  SEL_ACK,     16'h0001);
        expect_v("front_swap",  SEL_FRONT,   16'h0001);
        expect_v("pend_commit", SEL_PENDING, 16'h0000);
        tick();
        expect_v("ack_one_cyc", SEL_ACK,     16'h0000);

        // back bank is now bank 0; this must not disturb the displayed pixel
        wr(7'd0, 6'd0, 12'h0F0);

        // ---------------- read and expansion ----------------
        rd("pix_red",    7'd24, 7'd34, 16'hF800);
        x = 7'd25;
        tick();
        expect_v("latency_hold", SEL_COLOR, 16'hF800);
        tick();
        expect_v("exp_8C3",      SEL_COLOR, 16'h8E66);
        rd("exp_FFF",    7'd26,  7'd34, 16'hFFFF);
        rd("drop_oob",   7'd24,  7'd35, 16'h1106);
        rd("last_pix",   7'd103, 7'd93, 16'h07E0);
        rd("border_xhi", 7'd104, 7'd34, 16'h0000);
        rd("border_xlo", 7'd23,  7'd34, 16'h0000);
        rd("border_ylo", 7'd24,  7'd33, 16'h0000);
        rd("border_yhi", 7'd24,  7'd94, 16'h0000);

        // ---------------- scaled instance ----------------
        wr_s(6'd0, 6'd0, 12'hF00);
        wr_s(6'd1, 6'd1, 12'h0F0);
        wr_s(6'd2, 6'd2, 12'hFF0);
        swap_req_s = 1'b1;
        tick();
        swap_req_s = 1'b0;
        frame_end(1'b1);
        expect_v("s_front", SEL_FRONT_S, 16'h0001);
        rd_s("s_2_2", 7'd2, 7'd2, 16'h07E0);
        rd_s("s_3_2", 7'd3, 7'd2, 16'h07E0);
        rd_s("s_2_3", 7'd2, 7'd3, 16'h07E0);
        rd_s("s_3_3", 7'd3, 7'd3, 16'h07E0);
        rd_s("s_1_1", 7'd1, 7'd1, 16'hF800);
        rd_s("s_0_0", 7'd0, 7'd0, 16'hF800);
        rd_s("s_4_4", 7'd4, 7'd4, 16'hFFE0);
        rd_s("s_5_5", 7'd5, 7'd5, 16'hFFE0);

        // ---------------- repeated request while pending ----------------
        swap_req = 1'b1;
        tick();
        tick();                         // second request lands in PENDING
        swap_req = 1'b0;
        expect_v("dup_pending", SEL_PENDING, 16'h0001);
        expect_v("dup_no_ack",  SEL_ACK,     16'h0000);
        frame_end(1'b0);
        expect_v("dup_ack",     SEL_ACK,     16'h0001);
        expect_v("dup_front",   SEL_FRONT,   16'h0000);
        tick();
        expect_v("dup_ack_off", SEL_ACK,     16'h0000);
        frame_end(1'b0);
        expect_v("idle_fe_ack",   SEL_ACK,   16'h0000);
        expect_v("idle_fe_front", SEL_FRONT, 16'h0000);

        // ---------------- request coinciding with frame end ----------------
        swap_req = 1'b1;
        x = 7'd127; y = 7'd127; next_pixel = 1'b1;
        tick();
        swap_req = 1'b0; next_pixel = 1'b0;
        expect_v("coin_pending", SEL_PENDING, 16'h0001);
        expect_v("coin_no_ack",  SEL_ACK,     16'h0000);
        expect_v("coin_front",   SEL_FRONT,   16'h0000);
        frame_end(1'b0);
        expect_v("coin_ack",     SEL_ACK,     16'h0001);
        expect_v("coin_front2",  SEL_FRONT,   16'h0001);

        // ---------------- reset while pending ----------------
        tick();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        expect_v("rp_pending", SEL_PENDING, 16'h0001);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        expect_v("rp_pend_clr", SEL_PENDING, 16'h0000);
        expect_v("rp_front",    SEL_FRONT,   16'h0000);
        frame_end(1'b0);
        expect_v("rp_no_ack",   SEL_ACK,     16'h0000);
        expect_v("rp_front2",   SEL_FRONT,   16'h0000);

        tick();
        tick();
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d queued expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
